// File: rtl/key_event_multi_pkg.sv
// Shared types and defaults for the multi-key event front-end.
// Holds channel state encodings, timing defaults and width helpers.
package key_event_multi_pkg;

  typedef enum logic [2:0] {
    KS_LOCKOUT,
    KS_IDLE,
    KS_HELD,
    KS_LONG_HELD,
    KS_GAP,
    KS_SECOND
  } key_state_t;

  localparam int unsigned DEF_DEB_CYC    = 1000000;
  localparam int unsigned DEF_LONG_CYC   = 100000000;
  localparam int unsigned DEF_DBL_GAP    = 15000000;
  localparam int unsigned DEF_REPEAT_CYC = 10000000;
  localparam int unsigned DEF_CNT_W      = 27;
  localparam int unsigned SYNC_STAGES    = 2;

  function automatic int unsigned bits_for(input int unsigned v);
    int unsigned n;
    n = 1;
    for (int i = 1; i < 32; i++) begin
      if ((v >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

  function automatic int unsigned max2(input int unsigned a,
                                       input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_chan.sv
// One key channel: 2-FF sync, debounce and press classifier FSM.
// Build option KEY_REPEAT_EN adds auto-repeat long pulses while held.
module key_event_chan
  import key_event_multi_pkg::*;
#(
  parameter int unsigned DEB_CYC  = DEF_DEB_CYC,
  parameter int unsigned LONG_CYC = DEF_LONG_CYC,
  parameter int unsigned DBL_GAP  = DEF_DBL_GAP,
  parameter int unsigned CNT_W    = DEF_CNT_W
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned REPEAT_CYC = DEF_REPEAT_CYC
`endif
) (
  input  logic sysclk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  =
    CNT_W'((DBL_GAP == 0) ? 0 : DBL_GAP - 1);
  localparam logic [CNT_W-1:0] LOCK_WAIT = CNT_W'(SYNC_STAGES);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] tmr_inc;
  key_state_t       st_q, st_d;
  logic             press_s;

  assign sync_d    = {sync_q[0], key_n};
  assign press_s   = ~sync_q[1];
  assign key_level = level_q;
  assign tmr_inc   = (&tmr_q) ? tmr_q : tmr_q + 1'b1;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b0;
      deb_q   <= '0;
      tmr_q   <= '0;
      st_q    <= KS_LOCKOUT;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      deb_q   <= deb_d;
      tmr_q   <= tmr_d;
      st_q    <= st_d;
    end
  end

  always_comb begin
    level_d = level_q;
    deb_d   = '0;
    if (press_s != level_q) begin
      if (deb_q == DEB_LAST) begin
        level_d = ~level_q;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end
  end

  // Lockout also waits for the preset sync chain to flush,
  // so a key held through reset is seen before leaving it.
  always_comb begin
    st_d         = st_q;
    tmr_d        = tmr_q;
    short_pulse  = 1'b0;
    long_pulse   = 1'b0;
    double_pulse = 1'b0;
    unique case (st_q)
      KS_LOCKOUT: begin
        tmr_d = tmr_inc;
        if (tmr_q >= LOCK_WAIT && !level_q && !press_s) begin
          st_d  = KS_IDLE;
          tmr_d = '0;
        end
      end
      KS_IDLE: begin
        tmr_d = '0;
        if (level_q) st_d = KS_HELD;
      end
      KS_HELD: begin
        tmr_d = tmr_inc;
        if (tmr_q == LONG_LAST) begin
          long_pulse = 1'b1;
          st_d       = KS_LONG_HELD;
          tmr_d      = '0;
        end else if (!level_q) begin
          tmr_d = '0;
          if (DBL_GAP == 0) begin
            short_pulse = 1'b1;
            st_d        = KS_IDLE;
          end else begin
            st_d = KS_GAP;
          end
        end
      end
      KS_LONG_HELD: begin
`ifdef KEY_REPEAT_EN
        tmr_d = tmr_inc;
        if (!level_q) begin
          st_d  = KS_IDLE;
          tmr_d = '0;
        end else if (tmr_q == REP_LAST) begin
          long_pulse = 1'b1;
          tmr_d      = '0;
        end
`else
        tmr_d = '0;
        if (!level_q) st_d = KS_IDLE;
`endif
      end
      KS_GAP: begin
        tmr_d = tmr_inc;
        if (tmr_q == GAP_LAST) begin
          short_pulse = 1'b1;
          st_d        = KS_IDLE;
          tmr_d       = '0;
        end else if (level_q) begin
          double_pulse = 1'b1;
          st_d         = KS_SECOND;
          tmr_d        = '0;
        end
      end
      KS_SECOND: begin
        tmr_d = '0;
        if (!level_q) st_d = KS_IDLE;
      end
      default: begin
        st_d  = KS_LOCKOUT;
        tmr_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_event_multi.sv
// N-channel key front-end: short/long/double press event pulses.
// Build option KEY_REPEAT_EN adds REPEAT_CYC auto-repeat of long.
module key_event_multi
  import key_event_multi_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 2,
  parameter int unsigned DEB_CYC  = DEF_DEB_CYC,
  parameter int unsigned LONG_CYC = DEF_LONG_CYC,
  parameter int unsigned DBL_GAP  = DEF_DBL_GAP,
  parameter int unsigned CNT_W    = DEF_CNT_W
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned REPEAT_CYC = DEF_REPEAT_CYC
`endif
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] short_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] double_pulse
);

`ifdef KEY_REPEAT_EN
  localparam int unsigned MAX_CYC =
    max2(max2(DEB_CYC, LONG_CYC), max2(DBL_GAP, REPEAT_CYC));
`else
  localparam int unsigned MAX_CYC =
    max2(max2(DEB_CYC, LONG_CYC), DBL_GAP);
`endif
  localparam int unsigned NEED_W = bits_for(MAX_CYC);

  if (CNT_W < NEED_W) begin : g_cnt_w_chk
    $error("key_event_multi: CNT_W too narrow for timing params");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_event_chan #(
      .DEB_CYC   (DEB_CYC),
      .LONG_CYC  (LONG_CYC),
      .DBL_GAP   (DBL_GAP),
      .CNT_W     (CNT_W)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_CYC(REPEAT_CYC)
`endif
    ) u_chan (
      .sysclk      (sysclk),
      .rst         (rst),
      .key_n       (key_n[i]),
      .key_level   (key_level[i]),
      .short_pulse (short_pulse[i]),
      .long_pulse  (long_pulse[i]),
      .double_pulse(double_pulse[i])
    );
  end

endmodule
